// File: rtl/eusci_uart_rx_brgen.sv
// ============================================================================
// eusci_uart_rx_brgen
// Receive-side baud-rate controller for the eUSCI UART. It detects the start
// bit, times every bit period from MCLK with UCBRx, UCOS16 and UCBRSx, and
// drives the mid-bit BITCLK used by the receive state machine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eusci_uart_rx_brgen #(
  parameter int MAX_BITS     = 13,
  parameter bit GLITCH_CHECK = 1'b1
) (
  input  logic        MCLK,
  input  logic        reset_n,
  input  logic        wUCSWRST,
  input  logic [15:0] wUCBR,
  input  logic        wUCOS16,
  input  logic [7:0]  wUCBRS,
  input  logic        Rx,
  input  logic        RxBusy,
  output logic        BITCLK,
  output logic        RxSample,
  output logic        BRActive,
  output logic [3:0]  BitIndex,
  output logic        rGlitch
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_INDEX = 4'(MAX_BITS - 1);

  state_t      state;
  logic [19:0] count;
  logic [19:0] n_len;
  logic [19:0] half_len;
  logic        rx_prev;

  logic [19:0] base_len;
  logic [3:0]  next_index;
  logic [19:0] len_first;
  logic [19:0] len_next;
  logic [19:0] count_inc;
  logic        start_det;
  logic        glitch_hit;
  logic        boundary;
  logic        terminate;

  // Bit periods shorter than 2 cycles would leave no room for a mid-bit edge.
  function automatic logic [19:0] clamp_len(input logic [19:0] len);
    return (len < 20'd2) ? 20'd2 : len;
  endfunction

  // Bit-period arithmetic and the frame control conditions.
  always_comb begin
    base_len   = wUCOS16 ? {wUCBR, 4'b0000} : {4'b0000, wUCBR};
    next_index = BitIndex + 4'd1;
    len_first  = clamp_len(base_len + {19'd0, wUCBRS[0]});
    len_next   = clamp_len(base_len + {19'd0, wUCBRS[next_index[2:0]]});
    count_inc  = count + 20'd1;
    start_det  = (state == ST_IDLE) && rx_prev && !Rx;
    glitch_hit = GLITCH_CHECK && (state == ST_RUN) && (BitIndex == 4'd0) &&
                 (count == half_len - 20'd1) && Rx;
    boundary   = (state == ST_RUN) && (count == n_len - 20'd1);
    terminate  = boundary &&
                 (((BitIndex != 4'd0) && !RxBusy) || (BitIndex == LAST_INDEX));
  end

  assign BRActive = (state == ST_RUN);

  // Frame state machine: start detect, bit timing, glitch abort, termination.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= 20'd0;
      n_len    <= 20'd2;
      half_len <= 20'd1;
      rx_prev  <= 1'b1;
      BITCLK   <= 1'b0;
      RxSample <= 1'b0;
      BitIndex <= 4'd0;
      rGlitch  <= 1'b0;
    end else if (wUCSWRST) begin
      state    <= ST_IDLE;
      count    <= 20'd0;
      n_len    <= 20'd2;
      half_len <= 20'd1;
      rx_prev  <= 1'b1;
      BITCLK   <= 1'b0;
      RxSample <= 1'b0;
      BitIndex <= 4'd0;
      rGlitch  <= 1'b0;
    end else begin
      rx_prev  <= Rx;
      RxSample <= 1'b0;
      rGlitch  <= 1'b0;
      case (state)
        ST_IDLE: begin
          BITCLK <= 1'b0;
          if (start_det) begin
            state    <= ST_RUN;
            count    <= 20'd0;
            BitIndex <= 4'd0;
            n_len    <= len_first;
            half_len <= len_first >> 1;
          end
        end
        ST_RUN: begin
          if (glitch_hit) begin
            // The start bit went high again before mid-bit: treat it as noise.
            state    <= ST_IDLE;
            count    <= 20'd0;
            BitIndex <= 4'd0;
            BITCLK   <= 1'b0;
            rGlitch  <= 1'b1;
          end else if (terminate) begin
            state    <= ST_IDLE;
            count    <= 20'd0;
            BitIndex <= 4'd0;
            BITCLK   <= 1'b0;
          end else if (boundary) begin
            // Back-to-back bits: the next period starts on this very edge.
            count    <= 20'd0;
            BitIndex <= next_index;
            n_len    <= len_next;
            half_len <= len_next >> 1;
            BITCLK   <= 1'b0;
          end else begin
            count    <= count_inc;
            BITCLK   <= (count_inc >= half_len);
            RxSample <= (count_inc >= half_len) && !BITCLK;
          end
        end
        default: begin
          state  <= ST_IDLE;
          BITCLK <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eusci_uart_rx_brgen.sv
// ============================================================================
// tb_eusci_uart_rx_brgen
// Randomized frames checked against a frame-timeline reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eusci_uart_rx_brgen;

  localparam int MAX_BITS = 13;

  logic        MCLK = 1'b0;
  logic        reset_n;
  logic        wUCSWRST;
  logic [15:0] wUCBR;
  logic        wUCOS16;
  logic [7:0]  wUCBRS;
  logic        Rx;
  logic        RxBusy;
  logic        BITCLK;
  logic        RxSample;
  logic        BRActive;
  logic [3:0]  BitIndex;
  logic        rGlitch;

  int errors = 0;
  int checks = 0;

  eusci_uart_rx_brgen #(
    .MAX_BITS    (MAX_BITS),
    .GLITCH_CHECK(1'b1)
  ) dut (
    .MCLK    (MCLK),
    .reset_n (reset_n),
    .wUCSWRST(wUCSWRST),
    .wUCBR   (wUCBR),
    .wUCOS16 (wUCOS16),
    .wUCBRS  (wUCBRS),
    .Rx      (Rx),
    .RxBusy  (RxBusy),
    .BITCLK  (BITCLK),
    .RxSample(RxSample),
    .BRActive(BRActive),
    .BitIndex(BitIndex),
    .rGlitch (rGlitch)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit length from the baud settings for a given bit index.
  function automatic int bit_len(int ucbr, int os16, int ucbrs, int idx);
    int n;
    n = (os16 != 0 ? 16 * ucbr : ucbr) + ((ucbrs >> (idx % 8)) & 1);
    return (n < 2) ? 2 : n;
  endfunction

  // {BITCLK, RxSample, BRActive, rGlitch, BitIndex}
  function automatic logic [7:0] outs_exp(bit bclk, bit samp, bit act, bit glt, int idx);
    return {bclk, samp, act, glt, 4'(idx)};
  endfunction

  function automatic logic [7:0] outs_obs();
    return {BITCLK, RxSample, BRActive, rGlitch, BitIndex};
  endfunction

  task automatic set_cfg(input int ucbr, input int os16, input int ucbrs);
    wUCBR   = 16'(ucbr);
    wUCOS16 = 1'(os16);
    wUCBRS  = 8'(ucbrs);
  endtask

  task automatic rand_cfg();
    if ($urandom % 4 == 0) set_cfg($urandom % 3, 1, $urandom % 256);
    else                   set_cfg($urandom % 7, 0, $urandom % 256);
  endtask

  task automatic idle_cycles(input int cycles, input string name);
    for (int j = 0; j < cycles; j++) begin
      @(posedge MCLK); #1;
      chk($sformatf("%s idle%0d", name, j), 32'(outs_obs()), 32'(outs_exp(0, 0, 0, 0, 0)));
    end
  endtask

  // One frame. Rx falls in the current cycle (k); RUN starts at the next edge.
  // drop: RxBusy is high while the frame is in bits below this index.
  // glitch_len: when nonzero, Rx returns high after that many edges (<= half).
  task automatic run_frame(input int drop, input int glitch_len, input bit edge_at_end,
                           input bit cfg_churn, input string name);
    int  bit_i, pos, len, last;
    bit  done, rx_edge, busy_edge;
    logic [7:0] exp;
    last = (drop < 1) ? 1 : drop;
    if (last > MAX_BITS - 1) last = MAX_BITS - 1;
    Rx     = 1'b0;
    RxBusy = (drop > 0);
    done   = 1'b0;
    bit_i  = 0;
    pos    = 0;
    len    = 2;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(posedge MCLK);
      rx_edge   = Rx;
      busy_edge = RxBusy;
      if (t == 0) begin
        bit_i = 0;
        pos   = 0;
        len   = bit_len(wUCBR, wUCOS16, wUCBRS, 0);
        exp   = outs_exp(0, 0, 1, 0, 0);
      end else if (bit_i == 0 && pos == len / 2 - 1 && rx_edge) begin
        done = 1'b1;
        exp  = outs_exp(0, 0, 0, 1, 0);
      end else if (pos == len - 1) begin
        if ((bit_i >= 1 && !busy_edge) || bit_i == MAX_BITS - 1) begin
          done = 1'b1;
          exp  = outs_exp(0, 0, 0, 0, 0);
        end else begin
          bit_i++;
          pos = 0;
          len = bit_len(wUCBR, wUCOS16, wUCBRS, bit_i);
          exp = outs_exp(0, 0, 1, 0, bit_i);
        end
      end else begin
        pos++;
        exp = outs_exp(pos >= len / 2, pos == len / 2, 1, 0, bit_i);
      end
      #1;
      chk($sformatf("%s t%0d", name, t), 32'(outs_obs()), 32'(exp));
      if (!done) begin
        RxBusy = (bit_i < drop);
        if (glitch_len > 0)                Rx = (t + 1 < glitch_len) ? 1'b0 : 1'b1;
        else if (bit_i == 0 && pos < len / 2) Rx = 1'b0;
        else if (bit_i == last)            Rx = (edge_at_end && pos == len - 1) ? 1'b0 : 1'b1;
        else                               Rx = 1'($urandom % 2);
        if (cfg_churn && ($urandom % 8 == 0)) rand_cfg();
      end
    end
    if (!done) chk($sformatf("%s timeout", name), 32'd0, 32'd1);
    RxBusy = 1'b0;
    if (edge_at_end) idle_cycles(3, {name, " late_edge"});
    Rx = 1'b1;
    idle_cycles(3, name);
  endtask

  task automatic wait_bitclk(input string name);
    bit seen;
    seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      @(posedge MCLK); #1;
      seen = BITCLK;
    end
    chk({name, " bitclk_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    reset_n  = 1'b1;
    wUCSWRST = 1'b0;
    Rx       = 1'b1;
    RxBusy   = 1'b0;
    set_cfg(4, 0, 0);
    #2 reset_n = 1'b0;
    @(posedge MCLK); @(posedge MCLK); #1;
    chk("reset", 32'(outs_obs()), 32'(outs_exp(0, 0, 0, 0, 0)));
    reset_n = 1'b1;
    idle_cycles(2, "post_reset");

    set_cfg(4, 0, 8'h00); run_frame(3, 0, 0, 0, "d_basic");
    set_cfg(4, 0, 8'h05); run_frame(15, 0, 0, 0, "d_ucbrs_forced");
    set_cfg(2, 1, 8'h00); run_frame(2, 0, 0, 0, "d_os16");
    set_cfg(8, 0, 8'h00); run_frame(0, 2, 0, 0, "d_glitch");
    set_cfg(4, 0, 8'h00); run_frame(1, 0, 0, 0, "d_after_glitch");
    set_cfg(4, 0, 8'h00); run_frame(10, 0, 1, 0, "d_busy10");
    set_cfg(0, 0, 8'h00); run_frame(2, 0, 0, 0, "d_min_len");

    for (int f = 0; f < 30; f++) begin
      int half0;
      rand_cfg();
      half0 = bit_len(wUCBR, wUCOS16, wUCBRS, 0) / 2;
      if ($urandom % 5 == 0)
        run_frame(0, 1 + ($urandom % half0), 0, 0, $sformatf("r%0d_glitch", f));
      else
        run_frame($urandom % 16, 0, 1'($urandom % 2), 1, $sformatf("r%0d", f));
    end

    // Asynchronous reset while BITCLK is high.
    set_cfg(4, 0, 8'h00);
    Rx = 1'b0;
    wait_bitclk("areset");
    #2 reset_n = 1'b0;
    #1 chk("areset mid_bit", 32'(outs_obs()), 32'(outs_exp(0, 0, 0, 0, 0)));
    Rx = 1'b1;
    @(posedge MCLK); #1;
    reset_n = 1'b1;
    idle_cycles(2, "areset_after");

    // Software reset while BITCLK is high; edges ignored while it is held.
    Rx = 1'b0;
    wait_bitclk("swrst");
    wUCSWRST = 1'b1;
    @(posedge MCLK); #1;
    chk("swrst mid_bit", 32'(outs_obs()), 32'(outs_exp(0, 0, 0, 0, 0)));
    Rx = 1'b1;
    @(posedge MCLK); #1;
    Rx = 1'b0;
    idle_cycles(2, "swrst_edge_ignored");
    Rx = 1'b1;
    @(posedge MCLK); #1;
    wUCSWRST = 1'b0;
    idle_cycles(2, "swrst_after");
    run_frame(4, 0, 0, 0, "d_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
